// File: rtl/hdmux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hdmux_arb_pkg
// Purpose : Shared types and constants for the hdmux2_arb slice
// Revision: 1.0 - initial release
// ============================================================================
package hdmux_arb_pkg;

  // Arbiter ownership states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Mux select encodings: 0 routes A0 (requester 0), 1 routes A1 (requester 1)
  localparam logic SEL_A0 = 1'b0;
  localparam logic SEL_A1 = 1'b1;

  // Beat counter must hold 0..maxburst
  function automatic int cnt_width(input int maxburst);
    return $clog2(maxburst + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hdmux2_arb_if.sv
`default_nettype none
// ============================================================================
// Module  : hdmux2_arb_if
// Purpose : Requester / downstream handshake bundle for hdmux2_arb
// Revision: 1.0 - initial release
// ============================================================================
interface hdmux2_arb_if #(
  parameter int W = 8
);
  logic         req0;
  logic         req1;
  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic         last0;
  logic         last1;
  logic         gnt0;
  logic         gnt1;
  logic         sl;
  logic         zv;
  logic [W-1:0] zd;
  logic         zsrc;
  logic         zrdy;

  // Requesters plus downstream consumer
  modport master (
    output req0, req1, d0, d1, last0, last1, zrdy,
    input  gnt0, gnt1, sl, zv, zd, zsrc
  );

  // Arbiter side
  modport slave (
    input  req0, req1, d0, d1, last0, last1, zrdy,
    output gnt0, gnt1, sl, zv, zd, zsrc
  );
endinterface
`default_nettype wire

// File: rtl/hdmux2_arb_mux.sv
`default_nettype none
// ============================================================================
// Module  : hdmuxb2_vec
// Purpose : W-bit inverting 2:1 mux, one cell per bit: Z = ~(SL ? A1 : A0)
// Revision: 1.0 - initial release
// ============================================================================
module hdmuxb2_vec
  import hdmux_arb_pkg::*;
#(
  parameter int W = 8
) (
  input  wire logic [W-1:0] a0_i,
  input  wire logic [W-1:0] a1_i,
  input  wire logic         sl_i,
  output logic      [W-1:0] z_o
);

  // One inverting mux cell per data bit
  generate
    for (genvar i = 0; i < W; i++) begin : g_bit
      assign z_o[i] = ~((sl_i == SEL_A1) ? a1_i[i] : a0_i[i]);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/hdmux2_arb.sv
`default_nettype none
// ============================================================================
// Module  : hdmux2_arb
// Purpose : Two-requester round-robin arbiter with burst cap, driving the
//           select of an inverting 2:1 mux and a one-entry output register
// Revision: 1.0 - initial release
// ============================================================================
module hdmux2_arb
  import hdmux_arb_pkg::*;
#(
  parameter int W        = 8,
  parameter int MAXBURST = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  hdmux2_arb_if.slave      bus
);

  localparam int             CW         = cnt_width(MAXBURST);
  localparam logic [CW-1:0]  c_CNT_LAST = CW'(MAXBURST - 1);

  arb_state_t    state_q, state_d;
  logic          sl_q, sl_d;
  logic          lp_q, lp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          zv_q, zv_d;
  logic [W-1:0]  zd_q, zd_d;
  logic          zsrc_q, zsrc_d;

  logic [W-1:0]  w_mux_z;
  logic          w_gnt0, w_gnt1;
  logic          w_own;
  logic          w_in_own;
  logic          w_req_own, w_req_oth, w_last_own;
  logic          w_xfer, w_release;

  hdmuxb2_vec #(.W(W)) u_mux (
    .a0_i (bus.d0),
    .a1_i (bus.d1),
    .sl_i (sl_q),
    .z_o  (w_mux_z)
  );

  // Grants depend only on registered state and downstream ready, never on REQ
  assign w_gnt0     = (state_q == OWN0) & (~zv_q | bus.zrdy);
  assign w_gnt1     = (state_q == OWN1) & (~zv_q | bus.zrdy);
  assign w_own      = (state_q == OWN1);
  assign w_in_own   = (state_q == OWN0) | (state_q == OWN1);
  assign w_req_own  = w_own ? bus.req1  : bus.req0;
  assign w_req_oth  = w_own ? bus.req0  : bus.req1;
  assign w_last_own = w_own ? bus.last1 : bus.last0;
  assign w_xfer     = (w_gnt0 & bus.req0) | (w_gnt1 & bus.req1);
  // An abandoned tenure has no transfer, so LAST plus REQ drop releases once
  assign w_release  = w_in_own &
                      (~w_req_own | (w_xfer & (w_last_own | (cnt_q == c_CNT_LAST))));

  assign bus.gnt0 = w_gnt0;
  assign bus.gnt1 = w_gnt1;
  assign bus.sl   = sl_q;
  assign bus.zv   = zv_q;
  assign bus.zd   = zd_q;
  assign bus.zsrc = zsrc_q;

  // Next-state: output register load/drain, then arbitration and release
  always_comb begin
    state_d = state_q;
    sl_d    = sl_q;
    lp_d    = lp_q;
    cnt_d   = cnt_q;
    zv_d    = zv_q;
    zd_d    = zd_q;
    zsrc_d  = zsrc_q;

    // Re-inverting the mux output recovers the owner's true-polarity data
    if (w_xfer) begin
      zd_d   = ~w_mux_z;
      zsrc_d = w_own;
      zv_d   = 1'b1;
      cnt_d  = cnt_q + CW'(1);
    end else if (bus.zrdy) begin
      zv_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // On a tie the requester not served last wins
        if (bus.req0 && (!bus.req1 || (lp_q == SEL_A1))) begin
          state_d = OWN0;
          sl_d    = SEL_A0;
          lp_d    = SEL_A0;
          cnt_d   = '0;
        end else if (bus.req1) begin
          state_d = OWN1;
          sl_d    = SEL_A1;
          lp_d    = SEL_A1;
          cnt_d   = '0;
        end
      end
      OWN0, OWN1: begin
        if (w_release) begin
          if (w_req_oth) begin
            // Zero-bubble handover to the waiting requester
            state_d = w_own ? OWN0 : OWN1;
            sl_d    = ~w_own;
            lp_d    = ~w_own;
            cnt_d   = '0;
          end else begin
            // SL keeps its value while nobody owns the path
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sl_q    <= SEL_A0;
      lp_q    <= SEL_A1;
      cnt_q   <= '0;
      zv_q    <= 1'b0;
      zd_q    <= '0;
      zsrc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sl_q    <= sl_d;
      lp_q    <= lp_d;
      cnt_q   <= cnt_d;
      zv_q    <= zv_d;
      zd_q    <= zd_d;
      zsrc_q  <= zsrc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hdmux2_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_hdmux2_arb
// Purpose : Directed self-checking bench for hdmux2_arb
// Revision: 1.0 - initial release
// ============================================================================
module tb_hdmux2_arb;

  localparam int W        = 8;
  localparam int MAXBURST = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hdmux2_arb_if #(.W(W)) bus ();

  hdmux2_arb #(.W(W), .MAXBURST(MAXBURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.d0    = '0;
    bus.d1    = '0;
    bus.last0 = 1'b0;
    bus.last1 = 1'b0;
    bus.zrdy  = 1'b1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.zv !== 1'b0)   begin failures++; $display("FAIL reset_zv got=%0b exp=0", bus.zv); end
    checks++; if (bus.zd !== 8'h00)  begin failures++; $display("FAIL reset_zd got=%h exp=00", bus.zd); end
    checks++; if (bus.zsrc !== 1'b0) begin failures++; $display("FAIL reset_zsrc got=%0b exp=0", bus.zsrc); end
    checks++; if (bus.sl !== 1'b0)   begin failures++; $display("FAIL reset_sl got=%0b exp=0", bus.sl); end
    checks++; if (bus.gnt0 !== 1'b0) begin failures++; $display("FAIL reset_gnt0 got=%0b exp=0", bus.gnt0); end
    checks++; if (bus.gnt1 !== 1'b0) begin failures++; $display("FAIL reset_gnt1 got=%0b exp=0", bus.gnt1); end
  endtask

  task automatic test_single();
    apply_reset();
    bus.req0 = 1'b1; bus.d0 = 8'hA5; bus.last0 = 1'b1;
    tick();
    checks++; if (bus.gnt0 !== 1'b1) begin failures++; $display("FAIL single_gnt0 got=%0b exp=1", bus.gnt0); end
    checks++; if (bus.gnt1 !== 1'b0) begin failures++; $display("FAIL single_gnt1 got=%0b exp=0", bus.gnt1); end
    checks++; if (bus.zv !== 1'b0)   begin failures++; $display("FAIL single_zv_c1 got=%0b exp=0", bus.zv); end
    tick();
    checks++; if (bus.zv !== 1'b1)   begin failures++; $display("FAIL single_zv_c2 got=%0b exp=1", bus.zv); end
    checks++; if (bus.zd !== 8'hA5)  begin failures++; $display("FAIL single_zd got=%h exp=a5", bus.zd); end
    checks++; if (bus.zsrc !== 1'b0) begin failures++; $display("FAIL single_zsrc got=%0b exp=0", bus.zsrc); end
    bus.req0 = 1'b0; bus.last0 = 1'b0;
    #1;
    checks++; if (bus.gnt0 !== 1'b0) begin failures++; $display("FAIL single_idle_gnt0 got=%0b exp=0", bus.gnt0); end
    checks++; if (bus.sl !== 1'b0)   begin failures++; $display("FAIL single_sl got=%0b exp=0", bus.sl); end
    tick();
    checks++; if (bus.zv !== 1'b0)   begin failures++; $display("FAIL single_drain_zv got=%0b exp=0", bus.zv); end
  endtask

  task automatic test_tie();
    logic       own;
    logic [7:0] exp_zd;
    apply_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.last0 = 1'b1; bus.last1 = 1'b1;
    bus.d0 = 8'h10; bus.d1 = 8'h20;
    tick();
    for (int k = 0; k < 4; k++) begin
      own    = k[0];
      exp_zd = own ? 8'h20 : 8'h10;
      checks++; if (bus.sl !== own) begin failures++; $display("FAIL tie_sl k=%0d got=%0b exp=%0b", k, bus.sl, own); end
      checks++; if ({bus.gnt1, bus.gnt0} !== (own ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL tie_gnt k=%0d got=%b%b exp_owner=%0b", k, bus.gnt1, bus.gnt0, own);
      end
      tick();
      checks++; if (bus.zsrc !== own || bus.zd !== exp_zd || bus.zv !== 1'b1) begin
        failures++; $display("FAIL tie_out k=%0d got zv=%0b zsrc=%0b zd=%h exp zv=1 zsrc=%0b zd=%h",
                             k, bus.zv, bus.zsrc, bus.zd, own, exp_zd);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_burst();
    logic [7:0] exp_zd;
    apply_reset();
    bus.req1 = 1'b1; bus.last1 = 1'b0;
    tick();
    bus.req0 = 1'b1; bus.last0 = 1'b1; bus.d0 = 8'h40;
    for (int b = 0; b < 4; b++) begin
      bus.d1 = 8'(8'h30 + b);
      exp_zd = 8'(8'h30 + b);
      #1;
      checks++; if (bus.gnt1 !== 1'b1) begin failures++; $display("FAIL burst_gnt1 b=%0d got=%0b exp=1", b, bus.gnt1); end
      tick();
      checks++; if (bus.zsrc !== 1'b1 || bus.zd !== exp_zd) begin
        failures++; $display("FAIL burst_beat b=%0d got zsrc=%0b zd=%h exp zsrc=1 zd=%h", b, bus.zsrc, bus.zd, exp_zd);
      end
    end
    checks++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      failures++; $display("FAIL burst_handover got gnt0=%0b gnt1=%0b exp gnt0=1 gnt1=0", bus.gnt0, bus.gnt1);
    end
    checks++; if (bus.sl !== 1'b0) begin failures++; $display("FAIL burst_sl got=%0b exp=0", bus.sl); end
    tick();
    checks++; if (bus.zsrc !== 1'b0 || bus.zd !== 8'h40 || bus.zv !== 1'b1) begin
      failures++; $display("FAIL burst_fifth got zv=%0b zsrc=%0b zd=%h exp zv=1 zsrc=0 zd=40", bus.zv, bus.zsrc, bus.zd);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus.req0 = 1'b1; bus.last0 = 1'b0; bus.d0 = 8'h01;
    tick();
    tick();
    checks++; if (bus.zd !== 8'h01 || bus.zv !== 1'b1) begin
      failures++; $display("FAIL bp_first got zv=%0b zd=%h exp zv=1 zd=01", bus.zv, bus.zd);
    end
    bus.d0 = 8'h02; bus.zrdy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++; if (bus.gnt0 !== 1'b0) begin failures++; $display("FAIL bp_gnt0 s=%0d got=%0b exp=0", s, bus.gnt0); end
      tick();
      checks++; if (bus.zd !== 8'h01 || bus.zv !== 1'b1) begin
        failures++; $display("FAIL bp_hold s=%0d got zv=%0b zd=%h exp zv=1 zd=01", s, bus.zv, bus.zd);
      end
    end
    bus.zrdy = 1'b1;
    #1;
    checks++; if (bus.gnt0 !== 1'b1) begin failures++; $display("FAIL bp_resume_gnt0 got=%0b exp=1", bus.gnt0); end
    tick();
    checks++; if (bus.zd !== 8'h02) begin failures++; $display("FAIL bp_second got=%h exp=02", bus.zd); end
    bus.d0 = 8'h03;
    tick();
    checks++; if (bus.zd !== 8'h03) begin failures++; $display("FAIL bp_third got=%h exp=03", bus.zd); end
    clear_inputs();
    tick();
  endtask

  task automatic test_abandon();
    apply_reset();
    bus.req0 = 1'b1; bus.last0 = 1'b0; bus.d0 = 8'h55;
    tick();
    tick();
    checks++; if (bus.zd !== 8'h55) begin failures++; $display("FAIL ab_beat got=%h exp=55", bus.zd); end
    bus.req0 = 1'b0; bus.req1 = 1'b1; bus.last1 = 1'b1; bus.d1 = 8'h66;
    tick();
    checks++; if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0 || bus.sl !== 1'b1) begin
      failures++; $display("FAIL ab_to_own1 got gnt0=%0b gnt1=%0b sl=%0b exp gnt0=0 gnt1=1 sl=1", bus.gnt0, bus.gnt1, bus.sl);
    end
    checks++; if (bus.zv !== 1'b0) begin failures++; $display("FAIL ab_no_beat got zv=%0b exp=0", bus.zv); end
    tick();
    checks++; if (bus.zd !== 8'h66 || bus.zsrc !== 1'b1) begin
      failures++; $display("FAIL ab_own1_beat got zsrc=%0b zd=%h exp zsrc=1 zd=66", bus.zsrc, bus.zd);
    end
    bus.last1 = 1'b0;
    tick();
    bus.req1 = 1'b0;
    tick();
    checks++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.sl !== 1'b1) begin
      failures++; $display("FAIL ab_idle got gnt0=%0b gnt1=%0b sl=%0b exp gnt0=0 gnt1=0 sl=1", bus.gnt0, bus.gnt1, bus.sl);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.req1 = 1'b1; bus.last1 = 1'b0; bus.d1 = 8'h77;
    tick();
    tick();
    tick();
    checks++; if (bus.sl !== 1'b1 || bus.zv !== 1'b1) begin
      failures++; $display("FAIL rm_pre got sl=%0b zv=%0b exp sl=1 zv=1", bus.sl, bus.zv);
    end
    rst = 1'b1;
    tick();
    checks++; if (bus.zv !== 1'b0 || bus.zd !== 8'h00 || bus.sl !== 1'b0) begin
      failures++; $display("FAIL rm_regs got zv=%0b zd=%h sl=%0b exp zv=0 zd=00 sl=0", bus.zv, bus.zd, bus.sl);
    end
    checks++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
      failures++; $display("FAIL rm_gnt got gnt0=%0b gnt1=%0b exp 0 0", bus.gnt0, bus.gnt1);
    end
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_tie();
    test_burst();
    test_backpressure();
    test_abandon();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hdmux2_arb.md
# hdmux2_arb

Two-requester round-robin arbiter and sequencer for a shared W-bit inverting 2:1 mux path (per bit Z = ~(SL ? A1 : A0)). It owns the mux select SL and grants the path to one requester at a time with a valid/ready handshake. Transfers may be bursts, capped at MAXBURST. It re-inverts the mux output into a one-entry output register, so the downstream side sees true-polarity data tagged with its source.

## Interface
- W, default 8: data width, W ≥ 1.
- MAXBURST, default 4: maximum transfers per tenure, MAXBURST ≥ 1.
- CK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- REQ0 / REQ1  in  1  requester i has data on Di.
- D0 / D1  in  W  requester data; sampled only on a transfer.
- LAST0 / LAST1  in  1  the current beat ends requester i's burst.
- GNT0 / GNT1  out  1  ready to requester i. A transfer happens when REQi & GNTi.
- SL  out  1  registered mux select: 0 = requester 0, 1 = requester 1.
- ZV  out  1  output register valid.
- ZD  out  W  output data, true polarity.
- ZSRC  out  1  source requester of ZD.
- ZRDY  in  1  downstream ready. Output transfer when ZV & ZRDY.

## Operation
- States: IDLE, OWN0, OWN1. Extra registers:
  - LP: last-served requester.
  - CNT: beats in the current tenure, width $clog2(MAXBURST+1).
- Reset values: state=IDLE, SL=0, LP=1 (requester 0 wins the first tie), CNT=0, ZV=0, ZD=0, ZSRC=0, GNT0=GNT1=0.
- IDLE arbitration:
  - Only REQi high: go to OWNi.
  - Both high: go to OWN(~LP).
  - Neither: stay in IDLE.
  - On entry to OWNi: SL←i, LP←i, CNT←0.
- GNTi = (state==OWNi) & (~ZV | ZRDY). It is combinational from registers and ZRDY only, never from REQ.
- Transfer in OWNi:
  - ZD ← ~mux_out, which equals Di.
  - ZSRC ← i, ZV ← 1, CNT ← CNT+1.
- Release from OWNi happens on any of:
  - a transfer with LASTi;
  - a transfer with CNT == MAXBURST-1 (forced end of burst);
  - REQi low while in OWNi (requester abandoned its tenure).
- On release:
  - If REQ of the other requester is high, go straight to OWN(other) with SL and LP updated and CNT←0.
  - Otherwise go to IDLE. SL holds its last value in IDLE and never toggles without an owner.
- Output register:
  - ZV & ~ZRDY: ZV, ZD and ZSRC hold stable.
  - ZV & ZRDY with no new transfer: ZV←0.
  - Output transfer and input transfer in the same cycle: the register is reloaded and ZV stays 1.
- Simultaneous events:
  - LASTi and REQi falling in the same cycle: one release, no double count.
  - Forced release while the other requester is idle: return to IDLE. If REQi is still high, requester i re-wins through IDLE arbitration.
- Reset mid-burst: next edge restores all reset values. The in-flight ZD is discarded.

## Timing
- REQi rising in IDLE at cycle 0:
  - cycle 1: state OWNi, SL valid, GNTi high (if the output register is free);
  - cycle 2: ZV=1 with Di.
  - Request to first output: 2 cycles.
- Throughput: 1 beat/cycle within a tenure while ZRDY is high.
- Owner handover when the other requester is waiting: zero bubble. The release-cycle beat comes from the old owner; the next cycle grants the new owner.
- Backpressure: ZRDY low with ZV high forces GNT low in the same cycle. No data is lost or duplicated.
- SL changes only on an edge where the state enters OWNi, and SL is stable for the whole tenure.

## Structure
- Package hdmux_arb_pkg:
  - state enum {IDLE, OWN0, OWN1};
  - constants SEL_A0=1'b0 and SEL_A1=1'b1;
  - a CNT-width function of MAXBURST.
- Sub-module hdmuxb2_vec (W-bit inverting mux, combinational, per-bit cell equation) provides the datapath. The arbiter instantiates it with A0=D0, A1=D1, SL and re-inverts its output before the register.
- All remaining logic (FSM, counters, output register) lives in hdmux2_arb.

## Test plan
- Single request: RST then REQ0=1, D0=8'hA5, LAST0=1 at cycle 0, ZRDY=1 → GNT0 in cycle 1, ZV=1 with ZD=8'hA5, ZSRC=0 in cycle 2, then state returns to IDLE and SL=0.
- Tie after reset: REQ0=REQ1=1, single-beat LAST → grants alternate 0,1,0,1 and SL toggles each tenure.
- Burst cap: MAXBURST=4, REQ1 held with LAST1=0, REQ0 waiting → exactly 4 beats with ZSRC=1, then zero-bubble handover, so the 5th beat has ZSRC=0.
- Backpressure: ZRDY=0 for 3 cycles mid-burst with D0 incrementing → GNT0 low during the stall, ZD holds, and the output sequence has no gaps or duplicates.
- Abandon: REQ0 drops in OWN0 before LAST0 → release next edge; with REQ1 high go to OWN1, otherwise IDLE with SL unchanged.
- Reset mid-burst: RST at beat 2 of 4 → next cycle ZV=0, GNT0=GNT1=0, SL=0, state IDLE.
